floattodouble: RTL



---
 rtl/fpu_pkg.sv | 19 +
 rtl/floattodouble.sv | 118 +++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU conversion constants: FSM state encoding and IEEE-754 exponent values
// used by the single/double precision converters.
package fpu_pkg;

  typedef enum logic [1:0] {
    GET_A     = 2'd0,
    UNPACK    = 2'd1,
    NORMALISE = 2'd2,
    PUT_Z     = 2'd3
  } state_t;

  localparam logic [10:0] SP_BIAS        = 11'd127;
  localparam logic [10:0] DP_BIAS        = 11'd1023;
  localparam logic [10:0] BIAS_DELTA     = DP_BIAS - SP_BIAS;
  localparam logic [10:0] DP_DENORM_BASE = BIAS_DELTA + 11'd1;
  localparam logic [7:0]  SP_EXP_MAX     = 8'd255;
  localparam logic [10:0] DP_EXP_MAX     = 11'd2047;

endpackage

// File: rtl/floattodouble.sv
// Multi-cycle IEEE-754 single-to-double converter with iterative denormal normalisation.
// Define FTOD_NAN_PAYLOAD_EN to propagate NaN payloads; otherwise NaNs become canonical quiet NaNs.
module floattodouble
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] input_a,
  output logic [63:0] output_z,
  output logic        complete
);

  state_t      state, state_d;
  logic [31:0] a, a_d;
  logic [23:0] m, m_d;
  logic [10:0] z_e, z_e_d;
  logic [63:0] z, z_d;
  logic [63:0] output_z_d;
  logic        complete_d;

  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic [50:0] nan_payload;

  assign exp_f  = a[30:23];
  assign frac_f = a[22:0];

`ifdef FTOD_NAN_PAYLOAD_EN
  assign nan_payload = {a[21:0], 29'b0};
`else
  assign nan_payload = '0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d    = state;
    a_d        = a;
    m_d        = m;
    z_e_d      = z_e;
    z_d        = z;
    output_z_d = output_z;
    complete_d = complete;

    unique case (state)
      GET_A: begin
        a_d        = input_a;
        complete_d = 1'b0;
        state_d    = UNPACK;
      end

      UNPACK: begin
        z_d[63] = a[31];
        state_d = PUT_Z;
        if (exp_f == 8'd0) begin
          if (frac_f == 23'd0) begin
            z_d[62:0] = '0;
          end else begin
            m_d     = {1'b0, frac_f};
            z_e_d   = DP_DENORM_BASE;
            state_d = NORMALISE;
          end
        end else if (exp_f == SP_EXP_MAX) begin
          z_d[62:52] = DP_EXP_MAX;
          if (frac_f == 23'd0) begin
            z_d[51:0] = '0;
          end else begin
            // Quiet bit forced high so signalling NaNs leave as quiet NaNs.
            z_d[51]   = 1'b1;
            z_d[50:0] = nan_payload;
          end
        end else begin
          z_d[62:52] = {3'b0, exp_f} + BIAS_DELTA;
          z_d[51:0]  = {frac_f, 29'b0};
        end
      end

      NORMALISE: begin
        if (m[23]) begin
          z_d[62:52] = z_e;
          z_d[51:0]  = {m[22:0], 29'b0};
          state_d    = PUT_Z;
        end else begin
          m_d   = {m[22:0], 1'b0};
          z_e_d = z_e - 11'd1;
        end
      end

      PUT_Z: begin
        output_z_d = z;
        complete_d = 1'b1;
        state_d    = GET_A;
      end

      default: state_d = GET_A;
    endcase
  end

  // NOTE: only the control and visible outputs are reset; the working registers
  // (a, m, z_e, z) are always written before being read after GET_A.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (!rst || !en) begin
      state    <= GET_A;
      output_z <= '0;
      complete <= 1'b0;
    end else begin
      state    <= state_d;
      output_z <= output_z_d;
      complete <= complete_d;
    end
    a   <= a_d;
    m   <= m_d;
    z_e <= z_e_d;
    z   <= z_d;
  end

endmodule
